// File: rtl/nvdla_dbb_rd_packer_if.sv
// Bundles the request, word-stream and DBB read-data handshakes of nvdla_dbb_rd_packer.
// slave = packer side, master = surrounding bridge/testbench side.
interface nvdla_dbb_rd_packer_if #(
    parameter int MEMIF_WIDTH = 64,
    parameter int ID_WIDTH    = 8,
    parameter int LEN_WIDTH   = 13
);
    logic                   req_valid_i;
    logic                   req_ready_o;
    logic [ID_WIDTH-1:0]    req_id_i;
    logic [LEN_WIDTH-1:0]   req_len_i;

    logic                   word_valid_i;
    logic                   word_ready_o;
    logic [31:0]            word_data_i;

    logic                   rd_valid_o;
    logic                   rd_ready_i;
    logic [MEMIF_WIDTH-1:0] rd_data_o;
    logic [ID_WIDTH-1:0]    rd_id_o;
    logic                   rd_last_o;

    modport slave (
        input  req_valid_i, req_id_i, req_len_i,
        input  word_valid_i, word_data_i,
        input  rd_ready_i,
        output req_ready_o, word_ready_o,
        output rd_valid_o, rd_data_o, rd_id_o, rd_last_o
    );

    modport master (
        output req_valid_i, req_id_i, req_len_i,
        output word_valid_i, word_data_i,
        output rd_ready_i,
        input  req_ready_o, word_ready_o,
        input  rd_valid_o, rd_data_o, rd_id_o, rd_last_o
    );
endinterface

// File: rtl/nvdla_dbb_rd_packer.sv
// Packs 32-bit TCDM words into MEMIF_WIDTH DBB read beats with id/last; NVDLA_DBB_RD_PACKER_CMD_FIFO_EN gives a 2-deep command queue.
// Latency: one IDLE load cycle per request, beat valid the cycle after its last lane is accepted.
// Backpressure: a held output beat stalls only the final-lane word (word_ready_o sees rd_ready_i combinationally).
module nvdla_dbb_rd_packer #(
    parameter int MEMIF_WIDTH = 64,
    parameter int ID_WIDTH    = 8,
    parameter int LEN_WIDTH   = 13
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    nvdla_dbb_rd_packer_if.slave   bus,
    output logic                   busy_o,
    output logic                   err_o
);
    localparam int RATIO  = MEMIF_WIDTH / 32;
    localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);
`ifdef NVDLA_DBB_RD_PACKER_CMD_FIFO_EN
    localparam int Q_DEPTH = 2;
`else
    localparam int Q_DEPTH = 1;
`endif

    typedef enum logic {IDLE, PACK} state_t;

    state_t                 state;
    logic [ID_WIDTH-1:0]    q_id  [Q_DEPTH];
    logic [LEN_WIDTH-1:0]   q_len [Q_DEPTH];
    logic [1:0]             q_cnt;
    logic [1:0]             q_wr_idx;
    logic                   q_push, q_pop;

    logic [LEN_WIDTH-1:0]   beat_cnt;
    logic [ID_WIDTH-1:0]    cur_id;
    logic [LANE_W-1:0]      lane;
    logic [MEMIF_WIDTH-1:0] acc;
    logic [MEMIF_WIDTH-1:0] beat_nxt;
    logic                   out_free, word_acc;

    logic                   rd_valid_q, rd_last_q;
    logic [MEMIF_WIDTH-1:0] rd_data_q;
    logic [ID_WIDTH-1:0]    rd_id_q;

`ifdef NVDLA_DBB_RD_PACKER_CMD_FIFO_EN
    assign bus.req_ready_o = (q_cnt != 2'(Q_DEPTH));
`else
    // Single outstanding request: the slot is held until the request finishes in PACK.
    assign bus.req_ready_o = (q_cnt == 2'd0) && (state == IDLE);
`endif

    assign q_push   = bus.req_valid_i && bus.req_ready_o;
    assign q_pop    = (state == IDLE) && (q_cnt != 2'd0);
    assign q_wr_idx = q_cnt - 2'(q_pop);

    assign out_free         = !rd_valid_q || bus.rd_ready_i;
    assign bus.word_ready_o = (state == PACK) && ((lane != LAST_LANE) || out_free);
    assign word_acc         = bus.word_valid_i && bus.word_ready_o;

    assign err_o  = q_pop && (q_len[0] == '0);
    assign busy_o = (state == PACK) || (q_cnt != 2'd0) || rd_valid_q;

    assign bus.rd_valid_o = rd_valid_q;
    assign bus.rd_data_o  = rd_data_q;
    assign bus.rd_id_o    = rd_id_q;
    assign bus.rd_last_o  = rd_last_q;

    always_comb begin
        beat_nxt = acc;
        for (int i = 0; i < RATIO; i++) begin
            if (lane == LANE_W'(i)) beat_nxt[32*i +: 32] = bus.word_data_i;
        end
    end

    // Shift-style queue: head always in slot 0, pop shifts the rest down.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            q_cnt <= 2'd0;
        end else begin
            for (int i = 0; i < Q_DEPTH; i++) begin
                if (q_push && (q_wr_idx == 2'(i))) begin
                    q_id[i]  <= bus.req_id_i;
                    q_len[i] <= bus.req_len_i;
                end else if (q_pop && (i < Q_DEPTH - 1)) begin
                    q_id[i]  <= q_id[(i + 1 < Q_DEPTH) ? i + 1 : i];
                    q_len[i] <= q_len[(i + 1 < Q_DEPTH) ? i + 1 : i];
                end
            end
            q_cnt <= q_cnt + 2'(q_push) - 2'(q_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            cur_id     <= '0;
            lane       <= '0;
            acc        <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_id_q    <= '0;
            rd_last_q  <= 1'b0;
        end else begin
            if (bus.rd_ready_i) rd_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (q_pop && (q_len[0] != '0)) begin
                        beat_cnt <= q_len[0];
                        cur_id   <= q_id[0];
                        lane     <= '0;
                        state    <= PACK;
                    end
                end
                PACK: begin
                    if (word_acc) begin
                        acc <= beat_nxt;
                        if (lane == LAST_LANE) begin
                            // A new beat overrides any same-cycle drain of the previous one.
                            lane       <= '0;
                            rd_valid_q <= 1'b1;
                            rd_data_q  <= beat_nxt;
                            rd_id_q    <= cur_id;
                            rd_last_q  <= (beat_cnt == LEN_WIDTH'(1));
                            beat_cnt   <= beat_cnt - LEN_WIDTH'(1);
                            if (beat_cnt == LEN_WIDTH'(1)) state <= IDLE;
                        end else begin
                            lane <= lane + LANE_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nvdla_dbb_rd_packer.sv
// Scoreboard bench for nvdla_dbb_rd_packer at MEMIF_WIDTH=64 with directed scenarios.
module tb_nvdla_dbb_rd_packer;
    logic clk_i = 1'b0;
    logic rst_i, clear_i;
    logic busy_o, err_o;

    always #5 clk_i = ~clk_i;

    nvdla_dbb_rd_packer_if #(.MEMIF_WIDTH(64), .ID_WIDTH(8), .LEN_WIDTH(13)) bus ();

    nvdla_dbb_rd_packer #(.MEMIF_WIDTH(64), .ID_WIDTH(8), .LEN_WIDTH(13)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .bus     (bus),
        .busy_o  (busy_o),
        .err_o   (err_o)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  id;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int vectors     = 0;
    int miscompares = 0;
    int beats_seen  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [63:0] data, input logic [7:0] id, input logic last);
        beat_t b;
        b.data = data; b.id = id; b.last = last;
        exp_q.push_back(b);
    endtask

    // Monitor: every accepted beat is popped from the scoreboard and compared.
    always @(negedge clk_i) begin
        beat_t e;
        if (!rst_i && bus.rd_valid_o && bus.rd_ready_i) begin
            beats_seen++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_beat: got data 0x%0h id 0x%0h, expected no beat",
                         bus.rd_data_o, bus.rd_id_o);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", bus.rd_data_o, e.data);
                check("beat_id",   64'(bus.rd_id_o), 64'(e.id));
                check("beat_last", 64'(bus.rd_last_o), 64'(e.last));
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_req(input logic [7:0] id, input logic [12:0] len, output int waits);
        bit done;
        done  = 1'b0;
        waits = 0;
        bus.req_valid_i = 1'b1;
        bus.req_id_i    = id;
        bus.req_len_i   = len;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk_i);
            if (bus.req_ready_o) done = 1'b1;
            else waits++;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL req_timeout: req_ready_o stayed 0, expected 1 within 200 cycles");
        end
        @(posedge clk_i);
        #1;
        bus.req_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        bit done;
        done = 1'b0;
        bus.word_valid_i = 1'b1;
        bus.word_data_i  = w;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk_i);
            if (bus.word_ready_o) done = 1'b1;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL word_timeout: word_ready_o stayed 0, expected 1 within 200 cycles");
        end
        @(posedge clk_i);
        #1;
        bus.word_valid_i = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_req_ready"},  64'(bus.req_ready_o),  64'd1);
        check({tag, "_word_ready"}, 64'(bus.word_ready_o), 64'd0);
        check({tag, "_rd_valid"},   64'(bus.rd_valid_o),   64'd0);
        check({tag, "_rd_last"},    64'(bus.rd_last_o),    64'd0);
        check({tag, "_busy"},       64'(busy_o),           64'd0);
        check({tag, "_err"},        64'(err_o),            64'd0);
        check({tag, "_rd_data"},    bus.rd_data_o,         64'd0);
        check({tag, "_rd_id"},      64'(bus.rd_id_o),      64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w1, w2, base;
        rst_i = 1'b1; clear_i = 1'b0;
        bus.req_valid_i = 1'b0; bus.req_id_i = '0; bus.req_len_i = '0;
        bus.word_valid_i = 1'b0; bus.word_data_i = '0;
        bus.rd_ready_i = 1'b1;
        tick(); tick();
        reset_checks("rst");
        rst_i = 1'b0;
        tick();

        // 1: basic packing
        push_exp(64'h2222222211111111, 8'h05, 1'b0);
        push_exp(64'h4444444433333333, 8'h05, 1'b1);
        send_req(8'h05, 13'd2, w1);
        send_word(32'h11111111);
        check("s1_no_early_valid", 64'(bus.rd_valid_o), 64'd0);
        send_word(32'h22222222);
        check("s1_beat1_latency", 64'(bus.rd_valid_o), 64'd1);
        send_word(32'h33333333);
        send_word(32'h44444444);
        check("s1_beat2_latency", 64'(bus.rd_valid_o), 64'd1);
        check("s1_beat2_last", 64'(bus.rd_last_o), 64'd1);
        repeat (3) tick();

        // 2: output backpressure
        push_exp(64'h2222222211111111, 8'h05, 1'b0);
        push_exp(64'h4444444433333333, 8'h05, 1'b1);
        send_req(8'h05, 13'd2, w1);
        send_word(32'h11111111);
        send_word(32'h22222222);
        bus.rd_ready_i = 1'b0;
        send_word(32'h33333333);
        check("s2_word_ready_drop", 64'(bus.word_ready_o), 64'd0);
        for (int i = 0; i < 10; i++) begin
            check("s2_hold_data", bus.rd_data_o, 64'h2222222211111111);
            tick();
        end
        check("s2_hold_valid", 64'(bus.rd_valid_o), 64'd1);
        bus.rd_ready_i = 1'b1;
        send_word(32'h44444444);
        repeat (3) tick();

        // 3: back-to-back requests
        push_exp(64'h1000000110000000, 8'h01, 1'b1);
        push_exp(64'h1000000310000002, 8'h02, 1'b0);
        push_exp(64'h1000000510000004, 8'h02, 1'b0);
        push_exp(64'h1000000710000006, 8'h02, 1'b1);
        base = beats_seen;
        fork
            begin
                send_req(8'h01, 13'd1, w1);
                send_req(8'h02, 13'd3, w2);
`ifdef NVDLA_DBB_RD_PACKER_CMD_FIFO_EN
                check("s3_req2_no_stall", 64'(w2), 64'd0);
`else
                check("s3_req2_stalled", 64'(w2 > 0), 64'd1);
                check("s3_req2_after_beat1", 64'(beats_seen >= base + 1), 64'd1);
`endif
            end
            begin
                for (int i = 0; i < 8; i++) send_word(32'h10000000 + 32'(i));
            end
        join
        repeat (3) tick();

        // 4: zero length
        send_req(8'h07, 13'd0, w1);
        check("s4_err_pulse", 64'(err_o), 64'd1);
        tick();
        check("s4_err_one_cycle", 64'(err_o), 64'd0);
        check("s4_no_valid", 64'(bus.rd_valid_o), 64'd0);
        push_exp(64'h0000000200000001, 8'h08, 1'b1);
        send_req(8'h08, 13'd1, w1);
        send_word(32'h00000001);
        send_word(32'h00000002);
        repeat (3) tick();

        // 5: abort mid-beat
        send_req(8'h09, 13'd2, w1);
        send_word(32'hDEADBEEF);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("s5_busy_cleared", 64'(busy_o), 64'd0);
        check("s5_valid_cleared", 64'(bus.rd_valid_o), 64'd0);
        push_exp(64'hBBBBBBBBAAAAAAAA, 8'h03, 1'b1);
        send_req(8'h03, 13'd1, w1);
        send_word(32'hAAAAAAAA);
        send_word(32'hBBBBBBBB);
        repeat (3) tick();

        // 6: reset with a beat pending
        bus.rd_ready_i = 1'b0;
        send_req(8'h06, 13'd1, w1);
        send_word(32'h66666666);
        send_word(32'h77777777);
        check("s6_pending", 64'(bus.rd_valid_o), 64'd1);
        rst_i = 1'b1;
        tick();
        reset_checks("s6_rst");
        rst_i = 1'b0;
        bus.rd_ready_i = 1'b1;
        repeat (5) tick();
        check("s6_never_presented", 64'(bus.rd_valid_o), 64'd0);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
